// File: rtl/tmr_pkg.sv
// Shared definitions for the memory-mapped timer: register offsets, bit
// positions, default ID word and the byte-lane merge used on writes.
package tmr_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_STATUS   = 3'd1;
    localparam logic [2:0] REG_COUNT    = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;
    localparam logic [2:0] REG_ID       = 3'd5;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_AUTO_RELOAD = 1;
    localparam int CTRL_IRQ_EN      = 2;

    localparam int STATUS_MATCH = 0;

    localparam logic [31:0] ID_DEFAULT = 32'h544D_5231;

    // Lanes whose active-low enable is 0 take the new byte; others keep the old one.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_value,
                                                input logic [31:0] new_value,
                                                input logic [3:0]  web);
        logic [31:0] result;
        result = old_value;
        for (int i = 0; i < 4; i++) begin
            if (!web[i]) begin
                result[8*i +: 8] = new_value[8*i +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/tmr_prescaler.sv
// 16-bit prescaler: pulses tick for one cycle every prescale+1 enabled cycles.
module tmr_prescaler (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        clr,
    input  logic [15:0] prescale,
    output logic        tick
);

    logic [15:0] cnt;

    assign tick = en && (cnt == prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/mmio_timer_responder.sv
// Timer peripheral on the CPU data-memory bus: prescaled 32-bit counter,
// compare match with optional auto-reload, and a level interrupt.
module mmio_timer_responder
    import tmr_pkg::*;
#(
    parameter int          ADDR_WIDTH = 14,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = ID_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  CS,
    input  logic                  OE,
    input  logic [3:0]            WEB,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] DI,
    output logic [DATA_WIDTH-1:0] DO,
    output logic                  irq
);

    // Bus protocol (SRAM-like, no handshake): every rising edge with CS=1 is
    // one access. WEB=4'hF reads (value before the edge lands in rdata, shown
    // on DO when OE=1); any cleared WEB bit writes that byte lane. No stalls.
    logic [2:0]  addr;
    logic        unused_addr;
    logic        bus_read;
    logic        bus_write;

    assign addr        = A[2:0];
    assign unused_addr = ^A[ADDR_WIDTH-1:3];
    assign bus_read    = CS && (WEB == 4'hF);
    assign bus_write   = CS && (WEB != 4'hF);

    logic [2:0]  ctrl;
    logic        match;
    logic [31:0] count;
    logic [31:0] compare;
    logic [15:0] prescale;
    logic [31:0] rdata;

    logic [31:0] reg_value;
    logic [31:0] wr_value;

    always_comb begin
        reg_value = '0;
        case (addr)
            REG_CTRL:     reg_value = {29'd0, ctrl};
            REG_STATUS:   reg_value = {31'd0, match};
            REG_COUNT:    reg_value = count;
            REG_COMPARE:  reg_value = compare;
            REG_PRESCALE: reg_value = {16'd0, prescale};
            REG_ID:       reg_value = ID_VALUE;
            default:      reg_value = '0;
        endcase
    end

    // Merging against the currently selected value lets each register take a slice.
    assign wr_value = merge_bytes(reg_value, DI, WEB);

    logic wr_ctrl;
    logic wr_status;
    logic wr_count;
    logic wr_compare;
    logic wr_prescale;

    assign wr_ctrl     = bus_write && (addr == REG_CTRL);
    assign wr_status   = bus_write && (addr == REG_STATUS);
    assign wr_count    = bus_write && (addr == REG_COUNT);
    assign wr_compare  = bus_write && (addr == REG_COMPARE);
    assign wr_prescale = bus_write && (addr == REG_PRESCALE);

    logic tick;

    tmr_prescaler u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl[CTRL_EN]),
        .clr      (wr_prescale),
        .prescale (prescale),
        .tick     (tick)
    );

    logic count_eq;
    logic match_set;
    logic match_clr;

    // A COUNT write on a tick cycle discards that tick's compare as well as its increment.
    assign count_eq  = (count == compare);
    assign match_set = tick && count_eq && !wr_count;
    assign match_clr = wr_status && !WEB[0] && DI[STATUS_MATCH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= '0;
            match    <= 1'b0;
            count    <= '0;
            compare  <= '0;
            prescale <= '0;
            rdata    <= '0;
        end else begin
            if (bus_read) begin
                rdata <= reg_value;
            end
            if (wr_ctrl) begin
                ctrl <= wr_value[2:0];
            end
            if (wr_compare) begin
                compare <= wr_value;
            end
            if (wr_prescale) begin
                prescale <= wr_value[15:0];
            end
            if (wr_count) begin
                count <= wr_value;
            end else if (tick) begin
                if (count_eq && ctrl[CTRL_AUTO_RELOAD]) begin
                    count <= '0;
                end else begin
                    count <= count + 32'd1;
                end
            end
            if (match_set) begin
                match <= 1'b1;
            end else if (match_clr) begin
                match <= 1'b0;
            end
        end
    end

    assign irq = ctrl[CTRL_IRQ_EN] && match;
    assign DO  = OE ? rdata : '0;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Self-checking bench for mmio_timer_responder: directed scenarios plus a
// randomized bus run, checked against a register-level behavioural model.
module tb_mmio_timer_responder;

    localparam logic [31:0] ID_WORD = 32'h544D_5231;

    logic        clk;
    logic        rst;
    logic        CS;
    logic        OE;
    logic [3:0]  WEB;
    logic [13:0] A;
    logic [31:0] DI;
    logic [31:0] DO;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    mmio_timer_responder #(
        .ADDR_WIDTH (14),
        .DATA_WIDTH (32),
        .ID_VALUE   (ID_WORD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .CS  (CS),
        .OE  (OE),
        .WEB (WEB),
        .A   (A),
        .DI  (DI),
        .DO  (DO),
        .irq (irq)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [2:0]  m_ctrl;
    logic        m_match;
    logic [31:0] m_count;
    logic [31:0] m_compare;
    logic [15:0] m_prescale;
    logic [31:0] m_rdata;
    int          m_phase;
    logic        m_oe;

    task automatic model_reset();
        m_ctrl = 0; m_match = 0; m_count = 0; m_compare = 0;
        m_prescale = 0; m_rdata = 0; m_phase = 0;
    endtask

    function automatic logic [31:0] model_reg(input logic [2:0] a);
        case (a)
            3'd0: return {29'd0, m_ctrl};
            3'd1: return {31'd0, m_match};
            3'd2: return m_count;
            3'd3: return m_compare;
            3'd4: return {16'd0, m_prescale};
            3'd5: return ID_WORD;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic model_do_bit_irq();
        return m_ctrl[2] && m_match;
    endfunction

    function automatic logic [31:0] model_do();
        return m_oe ? m_rdata : 32'd0;
    endfunction

    // True when the coming edge is a prescaler tick that finds COUNT==COMPARE.
    function automatic logic match_tick_next();
        return m_ctrl[0] && (m_phase == int'(m_prescale)) && (m_count == m_compare);
    endfunction

    task automatic model_edge(input logic cs, input logic [3:0] web,
                              input logic [2:0] a, input logic [31:0] di);
        logic [31:0] old_val, merged, n_count;
        logic        en, tick, is_wr, n_match, hit;
        int          n_phase;
        en     = m_ctrl[0];
        tick   = en && (m_phase == int'(m_prescale));
        is_wr  = cs && (web != 4'hF);
        old_val = model_reg(a);
        merged = old_val;
        for (int i = 0; i < 4; i++)
            if (!web[i]) merged[8*i +: 8] = di[8*i +: 8];

        n_phase = (!en || tick || (is_wr && a == 3'd4)) ? 0 : m_phase + 1;
        n_count = m_count;
        n_match = m_match;
        hit = 1'b0;
        if (is_wr && a == 3'd2) begin
            n_count = merged;
        end else if (tick) begin
            if (m_count == m_compare) begin
                hit = 1'b1;
                n_count = m_ctrl[1] ? 32'd0 : m_count + 32'd1;
            end else begin
                n_count = m_count + 32'd1;
            end
        end
        if (is_wr && a == 3'd1 && !web[0] && di[0]) n_match = 1'b0;
        if (hit) n_match = 1'b1;

        if (cs && web == 4'hF) m_rdata = old_val;
        if (is_wr && a == 3'd0) m_ctrl = merged[2:0];
        if (is_wr && a == 3'd3) m_compare = merged;
        if (is_wr && a == 3'd4) m_prescale = merged[15:0];
        m_count = n_count;
        m_match = n_match;
        m_phase = n_phase;
    endtask

    // ---------------- driver tasks ----------------
    task automatic bus(input logic cs, input logic oe, input logic [3:0] web,
                       input logic [2:0] a, input logic [31:0] di);
        logic [10:0] hi;
        hi  = 11'($urandom);
        CS  = cs;
        OE  = oe;
        WEB = web;
        A   = {hi, a};
        DI  = di;
        m_oe = oe;
        @(posedge clk);
        model_edge(cs, web, a, di);
        #1;
    endtask

    task automatic rd(input logic [2:0] a);
        bus(1'b1, 1'b1, 4'hF, a, 32'($urandom));
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] web, input logic [31:0] d);
        bus(1'b1, 1'b1, web, a, d);
    endtask

    task automatic idle();
        bus(1'b0, 1'b1, 4'hF, 3'd0, 32'd0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] exp_vals [6];
        exp_vals[0] = 0; exp_vals[1] = 0; exp_vals[2] = 0;
        exp_vals[3] = 0; exp_vals[4] = 0; exp_vals[5] = ID_WORD;
        rst = 1'b1; CS = 0; OE = 1; WEB = 4'hF; A = 0; DI = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (DO !== 32'd0) begin failures++; $display("FAIL reset_do: got %h expected 0", DO); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
        rst = 1'b0;
        for (int a = 0; a < 6; a++) begin
            rd(3'(a));
            checks++;
            if (DO !== exp_vals[a]) begin
                failures++;
                $display("FAIL reset_read[%0d]: got %h expected %h", a, DO, exp_vals[a]);
            end
        end
        bus(1'b0, 1'b0, 4'hF, 3'd5, 32'd0);
        checks++;
        if (DO !== 32'd0) begin failures++; $display("FAIL oe_low_do: got %h expected 0", DO); end
    endtask

    task automatic test_byte_write();
        wr(3'd3, 4'b1100, 32'hAABB_CCDD);
        rd(3'd3);
        checks++;
        if (DO !== 32'h0000_CCDD) begin failures++; $display("FAIL byte_write_compare: got %h expected 0000ccdd", DO); end
        wr(3'd5, 4'b0000, 32'($urandom));
        wr(3'd7, 4'b0000, 32'($urandom));
        rd(3'd5);
        checks++;
        if (DO !== ID_WORD) begin failures++; $display("FAIL id_readonly: got %h expected %h", DO, ID_WORD); end
        rd(3'd7);
        checks++;
        if (DO !== 32'd0) begin failures++; $display("FAIL reg7_zero: got %h expected 0", DO); end
        rd(3'd3);
        checks++;
        if (DO !== 32'h0000_CCDD) begin failures++; $display("FAIL compare_unchanged: got %h expected 0000ccdd", DO); end
    endtask

    task automatic test_auto_reload();
        wr(3'd4, 4'b0000, 32'd2);
        wr(3'd3, 4'b0000, 32'd3);
        wr(3'd2, 4'b0000, 32'd0);
        wr(3'd1, 4'b1110, 32'd1);
        wr(3'd0, 4'b0000, 32'd7);
        for (int c = 0; c < 14; c++) begin
            rd(3'd2);
            checks++;
            if (DO !== model_do()) begin failures++; $display("FAIL reload_count[%0d]: got %h expected %h", c, DO, model_do()); end
            checks++;
            if (irq !== model_do_bit_irq()) begin failures++; $display("FAIL reload_irq[%0d]: got %b expected %b", c, irq, model_do_bit_irq()); end
        end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL reload_irq_high: got %b expected 1", irq); end
        rd(3'd2);
        checks++;
        if (DO !== 32'd0) begin failures++; $display("FAIL reload_count_zero: got %h expected 0", DO); end
    endtask

    task automatic test_no_reload();
        bit found;
        wr(3'd0, 4'b0000, 32'd0);
        wr(3'd2, 4'b0000, 32'd0);
        wr(3'd1, 4'b1110, 32'd1);
        wr(3'd0, 4'b0000, 32'd5);
        for (int c = 0; c < 16; c++) begin
            rd(3'd2);
            checks++;
            if (DO !== model_do()) begin failures++; $display("FAIL noreload_count[%0d]: got %h expected %h", c, DO, model_do()); end
        end
        rd(3'd1);
        checks++;
        if (DO !== 32'd1) begin failures++; $display("FAIL noreload_match: got %h expected 1", DO); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL noreload_irq: got %b expected 1", irq); end
        wr(3'd1, 4'b1110, 32'd1);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL w1c_irq_low: got %b expected 0", irq); end
        // Re-arm, then drop IRQ_EN to see irq fall with MATCH still set.
        wr(3'd2, 4'b0000, 32'd3);
        found = 0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (match_tick_next()) begin
                wr(3'd1, 4'b1110, 32'd1);
                found = 1;
            end else begin
                idle();
            end
        end
        checks++;
        if (!found) begin failures++; $display("FAIL w1c_on_tick_timeout: got no match tick expected one within 20 cycles"); end
        rd(3'd1);
        checks++;
        if (DO !== 32'd1) begin failures++; $display("FAIL w1c_set_wins: got %h expected 1", DO); end
        wr(3'd0, 4'b0000, 32'd1);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL irq_en_clear: got %b expected 0", irq); end
    endtask

    task automatic test_wrap();
        wr(3'd0, 4'b0000, 32'd0);
        wr(3'd4, 4'b0000, 32'd0);
        wr(3'd3, 4'b0000, 32'd5);
        wr(3'd2, 4'b0000, 32'hFFFF_FFFF);
        wr(3'd1, 4'b1110, 32'd1);
        wr(3'd0, 4'b0000, 32'd1);
        rd(3'd2);
        checks++;
        if (DO !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_before: got %h expected ffffffff", DO); end
        rd(3'd2);
        checks++;
        if (DO !== 32'd0) begin failures++; $display("FAIL wrap_after: got %h expected 0", DO); end
        rd(3'd1);
        checks++;
        if (DO !== 32'd0) begin failures++; $display("FAIL wrap_no_match: got %h expected 0", DO); end
        wr(3'd2, 4'b0000, 32'd100);
        rd(3'd2);
        checks++;
        if (DO !== 32'd100) begin failures++; $display("FAIL count_write_on_tick: got %h expected 100", DO); end
    endtask

    task automatic test_random();
        logic        cs, oe;
        logic [3:0]  web;
        logic [2:0]  a;
        logic [31:0] d;
        wr(3'd0, 4'b0000, 32'd0);
        for (int c = 0; c < 400; c++) begin
            cs  = ($urandom_range(0, 3) != 0);
            oe  = ($urandom_range(0, 3) != 0);
            web = ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom);
            a   = 3'($urandom);
            d   = $urandom;
            if (a == 3'd4) d = 32'($urandom_range(0, 3));
            if (a == 3'd2 || a == 3'd3) d = 32'($urandom_range(0, 12));
            if (a == 3'd0 && ($urandom_range(0, 3) != 0)) d = d | 32'd1;
            bus(cs, oe, web, a, d);
            checks++;
            if (DO !== model_do()) begin failures++; $display("FAIL random_do[%0d]: got %h expected %h", c, DO, model_do()); end
            checks++;
            if (irq !== model_do_bit_irq()) begin failures++; $display("FAIL random_irq[%0d]: got %b expected %b", c, irq, model_do_bit_irq()); end
        end
    endtask

    task automatic test_reset_mid();
        wr(3'd0, 4'b0000, 32'd0);
        wr(3'd4, 4'b0000, 32'd0);
        wr(3'd3, 4'b0000, 32'd7);
        wr(3'd2, 4'b0000, 32'd7);
        wr(3'd1, 4'b1110, 32'd1);
        wr(3'd0, 4'b0000, 32'd5);
        rd(3'd2);
        checks++;
        if (DO !== 32'd7) begin failures++; $display("FAIL premid_count: got %h expected 7", DO); end
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL premid_irq: got %b expected 1", irq); end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (DO !== 32'd0) begin failures++; $display("FAIL async_reset_do: got %h expected 0", DO); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL async_reset_irq: got %b expected 0", irq); end
        CS = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int a = 0; a < 5; a++) begin
            rd(3'(a));
            checks++;
            if (DO !== 32'd0) begin failures++; $display("FAIL post_reset_read[%0d]: got %h expected 0", a, DO); end
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_byte_write();
        test_auto_reload();
        test_no_reload();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmio_timer_responder.md
# mmio_timer_responder

Memory-mapped timer peripheral that answers the CPU data-memory port with the same protocol as the data SRAM: chip select, output enable, active-low per-byte write enables, and read data valid one cycle after the address is captured. It sits beside the data SRAM on the CPU's DM bus, selected by an external address decode. It provides a prescaled 32-bit counter, a compare match with optional auto-reload, and a level interrupt.

## Interface
- ADDR_WIDTH, 14, word-address width, matching the DM port.
- DATA_WIDTH, 32, data width. Only 32 is supported.
- ID_VALUE, 32'h544D_5231, read-only identification word.

- clk  in  1  clock; every register updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- CS  in  1  chip select, active high.
- OE  in  1  output enable, active high.
- WEB  in  4  byte write enables, active low; WEB[i] controls DI[8i+7:8i].
- A  in  ADDR_WIDTH  word address; only A[2:0] is decoded.
- DI  in  32  write data.
- DO  out  32  read data.
- irq  out  1  interrupt, level-sensitive, active high.

## Operation
- Access type, sampled at each rising edge with CS=1:
  - WEB=4'hF is a read. The read-data register captures the selected register's value as it was before that edge.
  - Any other WEB value is a write. Only the enabled byte lanes change. The read-data register holds.
  - With CS=0, nothing is accessed and the read-data register holds.
- DO = OE ? read-data register : 32'h0.
- Register map (A[2:0]):
  - 0 CTRL: bit0 EN, bit1 AUTO_RELOAD, bit2 IRQ_EN. Bits 31:3 read 0.
  - 1 STATUS: bit0 MATCH, sticky. Writing 1 to bit0 with lane 0 enabled clears it.
  - 2 COUNT: 32-bit counter, read/write.
  - 3 COMPARE: 32-bit, read/write.
  - 4 PRESCALE: bits 15:0 read/write; bits 31:16 read 0.
  - 5 ID: reads ID_VALUE; writes are ignored.
  - 6, 7: read 0; writes are ignored.
- Prescaler:
  - A 16-bit counter runs while EN=1. It asserts `tick` for one cycle when it equals PRESCALE, then returns to 0. A tick therefore occurs every PRESCALE+1 cycles.
  - It is forced to 0 while EN=0 and on any PRESCALE write.
- Counter, on each tick:
  - If COUNT==COMPARE: MATCH is set; COUNT becomes 0 if AUTO_RELOAD=1, else COUNT+1.
  - Otherwise COUNT becomes COUNT+1, wrapping from 0xFFFF_FFFF to 0 with no flag.
- irq = IRQ_EN & MATCH, registered-source combinational output.
- Simultaneous events:
  - A COUNT write in the same cycle as a tick: the write wins and that tick's increment and compare are discarded.
  - A MATCH set in the same cycle as a W1C: the set wins.
  - A COMPARE write in the same cycle as a tick: the compare uses the old COMPARE value.

## Timing
- Reset values:
  - DO = 0.
  - irq = 0.
  - CTRL, STATUS, COUNT, COMPARE, PRESCALE = 0.
  - Prescaler counter and read-data register = 0.
- Read latency is one cycle. With the address captured at edge N, DO is valid after edge N and held until the next read edge.
- A write at edge N is visible to a read captured at edge N+1.
- COUNT first changes PRESCALE+1 cycles after the edge where EN goes to 1.
- irq rises in the cycle after the tick edge that sets MATCH. It falls in the cycle after the W1C edge, or after the edge that clears IRQ_EN.
- Reset asserted mid-operation clears all state immediately. The first access after deassertion behaves as after power-up.

## Structure
- Shared package `tmr_pkg`:
  - Register offsets REG_CTRL…REG_ID.
  - CTRL bit indices.
  - MATCH bit index.
  - Default ID_VALUE constant.
- Sub-module `tmr_prescaler`: 16-bit prescaler counter with clk, rst, en, clr, prescale and tick ports.
- Register file, bus decode and counter logic live in the top module. Byte-lane merging is a function in `tmr_pkg`.

## Test plan
- Reset, then read CTRL/STATUS/COUNT/COMPARE/PRESCALE/ID with OE=1 → 0, 0, 0, 0, 0, 32'h544D_5231, each one cycle after its address edge. With OE=0, DO=0.
- Write COMPARE with WEB=4'b1100, DI=32'hAABB_CCDD, then read it → 32'h0000_CCDD. Write addresses 5 and 7 → subsequent reads unchanged.
- PRESCALE=2, COMPARE=3, CTRL=3'b111 → COUNT steps 0,1,2,3 every 3 cycles. MATCH and irq go high after the tick at COUNT=3, and COUNT becomes 0.
- Same setup with AUTO_RELOAD=0 → COUNT goes 3→4 and MATCH is still set. Writing STATUS=1 clears irq the next cycle. A W1C issued on a match tick leaves MATCH=1.
- COUNT=32'hFFFF_FFFF, COMPARE=5, PRESCALE=0, EN=1 → COUNT becomes 0 the next cycle, with no MATCH. Writing COUNT=100 on a tick cycle → reads 100.
- Assert rst while EN=1 and COUNT=7 → all outputs and registers return to 0 asynchronously, before the next clk edge.
